// File: rtl/rf_writeback_queue.sv
// In-order writeback queue in front of the register file write port.
// Accepts one ALU or load writeback per cycle (load wins), drains one write per cycle.
module rf_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     wb_stall,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_reg,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     idx;

  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;

  always_comb begin
    full      = (count == CW'(DEPTH));
    mem_ready = !full;
    alu_ready = !full && !mem_valid;
    in_reg    = alu_reg;
    in_data   = alu_data;
    push      = 1'b0;
    // Register-0 requests are handshaken but never stored.
    if (mem_valid && mem_ready) begin
      in_reg  = mem_reg;
      in_data = mem_data;
      push    = (mem_reg != '0);
    end else if (alu_valid && alu_ready) begin
      push    = (alu_reg != '0);
    end
    pop = (count != '0) && !wb_stall;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      regs_q[tail] <= in_reg;
      data_q[tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) begin
        write_reg  <= regs_q[head];
        write_data <= data_q[head];
        head       <= head + PW'(1);
        regWrite   <= 1'b1;
      end else begin
        regWrite   <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (fwd_reg != '0) && (regs_q[idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed-vector bench for rf_writeback_queue with hand-computed expectations.
module tb_rf_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wb_stall;
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  rf_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".regWrite"}, 32'(regWrite), 32'(w));
    chk({tag, ".write_reg"}, 32'(write_reg), 32'(r));
    chk({tag, ".write_data"}, write_data, d);
  endtask

  task automatic alu_push(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1'b1; alu_reg = r; alu_data = d;
    tick;
    alu_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0; wb_stall = 1'b0; fwd_reg = 5'd9;
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst.count", 32'(count), 0);
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.fwd_hit", 32'(fwd_hit), 0);

    // single ALU write, 2-edge latency, no bypass on empty queue
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'd6;
    #1;
    chk("t1.alu_ready", 32'(alu_ready), 1);
    tick;
    alu_valid = 1'b0;
    #1;
    chk("t1.count_after_push", 32'(count), 1);
    chk("t1.no_bypass", 32'(regWrite), 0);
    chk("t1.fwd_hit", 32'(fwd_hit), 1);
    chk("t1.fwd_data", fwd_data, 32'd6);
    tick;
    chk_wr("t1.write", 1'b1, 5'd9, 32'd6);
    chk("t1.count_drained", 32'(count), 0);
    chk("t1.fwd_excl_output", 32'(fwd_hit), 0);
    tick;
    chk_wr("t1.one_pulse", 1'b0, 5'd9, 32'd6);

    // mem priority over alu, back-to-back writes
    mem_valid = 1'b1; mem_reg = 5'd10; mem_data = 32'd7;
    alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'd8;
    #1;
    chk("t2.mem_ready", 32'(mem_ready), 1);
    chk("t2.alu_ready", 32'(alu_ready), 0);
    tick;
    mem_valid = 1'b0;
    #1;
    chk("t2.count1", 32'(count), 1);
    chk("t2.alu_ready_now", 32'(alu_ready), 1);
    tick;
    alu_valid = 1'b0;
    chk_wr("t2.w10", 1'b1, 5'd10, 32'd7);
    chk("t2.count_pushpop", 32'(count), 1);
    tick;
    chk_wr("t2.w11", 1'b1, 5'd11, 32'd8);
    chk("t2.count0", 32'(count), 0);
    tick;
    chk("t2.idle", 32'(regWrite), 0);

    // fill under stall, fifth request refused, drain in order
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) alu_push(5'(12 + i), 32'(1 + i));
    chk("t3.count_full", 32'(count), 4);
    chk("t3.stall_no_write", 32'(regWrite), 0);
    alu_valid = 1'b1; alu_reg = 5'd16; alu_data = 32'd9;
    #1;
    chk("t3.alu_ready_full", 32'(alu_ready), 0);
    chk("t3.mem_ready_full", 32'(mem_ready), 0);
    tick;
    alu_valid = 1'b0;
    chk("t3.count_still_full", 32'(count), 4);
    wb_stall = 1'b0;
    #1;
    chk("t3.ready_low_while_popping", 32'(alu_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_wr($sformatf("t3.drain%0d", i), 1'b1, 5'(12 + i), 32'(1 + i));
      chk($sformatf("t3.count%0d", i), 32'(count), 32'(3 - i));
      if (i == 0) chk("t3.ready_back", 32'(alu_ready), 1);
    end
    tick;
    chk("t3.idle", 32'(regWrite), 0);

    // duplicate destination: youngest forwarded, both written in order
    wb_stall = 1'b1;
    alu_push(5'd9, 32'd5);
    alu_push(5'd9, 32'hAA);
    fwd_reg = 5'd9; #1;
    chk("t4.fwd_hit", 32'(fwd_hit), 1);
    chk("t4.fwd_youngest", fwd_data, 32'hAA);
    fwd_reg = 5'd0; #1;
    chk("t4.fwd_r0_hit", 32'(fwd_hit), 0);
    chk("t4.fwd_r0_data", fwd_data, 32'd0);
    fwd_reg = 5'd3; #1;
    chk("t4.fwd_miss", 32'(fwd_hit), 0);
    fwd_reg = 5'd9;
    wb_stall = 1'b0;
    tick;
    chk_wr("t4.w5", 1'b1, 5'd9, 32'd5);
    chk("t4.fwd_remaining", fwd_data, 32'hAA);
    wb_stall = 1'b1;
    tick;
    chk_wr("t4.stall_hold", 1'b0, 5'd9, 32'd5);
    chk("t4.count1", 32'(count), 1);
    wb_stall = 1'b0;
    tick;
    chk_wr("t4.wAA", 1'b1, 5'd9, 32'hAA);
    chk("t4.fwd_gone", 32'(fwd_hit), 0);
    tick;

    // register 0 handshaken, dropped
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    chk("t5.alu_ready", 32'(alu_ready), 1);
    tick;
    alu_valid = 1'b0;
    chk("t5.count", 32'(count), 0);
    tick;
    chk("t5.no_write", 32'(regWrite), 0);
    tick;
    chk("t5.no_write2", 32'(regWrite), 0);

    // reset discards queued entries
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) alu_push(5'(1 + i), 32'(32'h100 + i));
    chk("t6.count3", 32'(count), 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    wb_stall = 1'b0;
    fwd_reg = 5'd1;
    #1;
    chk("t6.count0", 32'(count), 0);
    chk("t6.fwd_cleared", 32'(fwd_hit), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_wr($sformatf("t6.nowrite%0d", i), 1'b0, 5'd0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Writer-side front end for the 32 x 32-bit register file: collects writeback requests from the ALU and the memory/load path, buffers them in an in-order queue, and drives the register file write port (`regWrite`, `write_reg`, `write_data`) at most one write per cycle. It sits between the execute/memory stages and the register file. It also exposes a forwarding lookup so the read side can take data still queued and not yet written.

## Interface
- `DEPTH`, 4, queue entries; power of two, at least 2.
- `DATA_W`, 32, register data width.
- `ADDR_W`, 5, register index width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_reg`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `alu_ready`  out  1  ALU request accepted this edge when high with `alu_valid`.
- `mem_valid`  in  1  load writeback request.
- `mem_reg`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load result.
- `mem_ready`  out  1  load request accepted this edge when high with `mem_valid`.
- `wb_stall`  in  1  high blocks draining the queue this cycle.
- `regWrite`  out  1  register file write strobe; registered, one-cycle pulse per entry.
- `write_reg`  out  ADDR_W  register file write index; registered.
- `write_data`  out  DATA_W  register file write data; registered.
- `fwd_reg`  in  ADDR_W  forwarding lookup index.
- `fwd_hit`  out  1  combinational; `fwd_reg` matches a queued entry.
- `fwd_data`  out  DATA_W  combinational; data of the youngest matching entry, 0 when no hit.
- `count`  out  clog2(DEPTH)+1  registered number of valid queue entries.

## Operation
- Circular queue of DEPTH entries {reg, data}, with head/tail pointers wrapping modulo DEPTH and a separate `count`.
- Enqueue: at most one per edge. `mem` has priority over `alu`.
  - `mem_ready = (count < DEPTH)`.
  - `alu_ready = (count < DEPTH) && !mem_valid`.
  - Both ready signals are combinational.
- Requests to register 0 are accepted (ready follows the rules above) but not stored. `count` is unchanged and no write is ever emitted for them.
- Drain: on each edge, if `count > 0` and `!wb_stall`, the head entry is popped into `write_reg`/`write_data` and `regWrite <= 1`. Otherwise `regWrite <= 0`, and `write_reg`/`write_data` hold their previous values.
- Push and pop on the same edge: the push goes to the tail and the pop takes the head, so `count` is unchanged. When `count == DEPTH`, ready is low even if a pop occurs that edge; there is no pass-through.
- Empty queue plus a push on the same edge: the entry is stored. It cannot be popped on that edge (no bypass).
- Writes leave in strict acceptance order. Two queued entries to the same register are both written, older first.
- Forwarding: `fwd_hit = (fwd_reg != 0) && any valid entry has reg == fwd_reg`. `fwd_data` is the data of the youngest such entry.
  - The entry currently held in the output registers is not included, because the register file already holds it.
  - A request being accepted on the current cycle is not included.
- Reset: head = tail = 0, `count = 0`, `regWrite = 0`, `write_reg = 0`, `write_data = 0`. All queued entries are discarded. `fwd_hit` reads 0 in the first cycle after reset.

## Timing
- A request accepted at edge E becomes the head no earlier than after edge E. With an empty queue and no stall, `regWrite` is high in the cycle after edge E+1, so latency is 2 edges from the accepting edge.
- Throughput: one accepted request per cycle and one register write per cycle.
- `regWrite` is never high for two cycles from one entry. Back-to-back entries produce back-to-back pulses with the new index/data each cycle.
- `wb_stall` is sampled at the edge. A stall while `regWrite` is high forces `regWrite` low on the next edge.
- Reset asserted at edge R overrides push and pop on that edge. No entry accepted before R is ever written afterwards.

## Test plan
- `alu_valid` for one cycle with reg=9, data=6, on an empty queue -> `alu_ready=1`; `regWrite=1`, `write_reg=9`, `write_data=6` for exactly one cycle, 2 edges later; `count` returns to 0.
- `mem_valid` (reg=10, data=7) and `alu_valid` (reg=11, data=8) in the same cycle -> `mem_ready=1`, `alu_ready=0`. Holding `alu_valid` for one more cycle yields writes to 10 then 11 on consecutive cycles.
- `wb_stall=1`, then push reg 12/13/14/15 with data 1..4 -> `count=4`, both ready signals 0, a fifth request is not accepted. Release the stall -> four consecutive writes 12..15 with data 1..4; ready returns the cycle after the first pop.
- Stall held, push reg 9 data 5, then reg 9 data 0xAA -> `fwd_reg=9` gives `fwd_hit=1`, `fwd_data=0xAA`; `fwd_reg=0` gives `fwd_hit=0`. Release -> write 5 then 0xAA to reg 9.
- Push reg 0 data 0xFFFFFFFF -> `alu_ready=1`, `count` stays 0, no `regWrite` pulse.
- Stall held, 3 entries queued; assert `reset` for one edge, then release the stall -> `count=0`, `regWrite` stays 0, no queued entry is written.
